im_loader: RTL and testbench
============================

// Module: im_loader
// PURPOSE
//   Boot-time program writer for the instruction memory.
//   - Accepts a big-endian byte stream over a valid/ready handshake.
//   - Packs every 4 bytes into a 32-bit instruction and writes it to consecutive IM word addresses from 0.
//   - Asserts Cpu_Hold while loading, so the datapath never fetches a partially written program.
// PARAMETERS
//   DEPTH   32  number of IM words (valid addresses 0..DEPTH-1)
//   ADDR_W  5   IM word-address width, equal to clog2(DEPTH)
//   WORD_W  32  instruction width; fixed at 4 bytes
// PORTS
//   Clk         in   1         rising-edge clock
//   Rst_n       in   1         asynchronous active-low reset
//   Start       in   1         one-cycle pulse that begins a load; honoured only in IDLE or DONE
//   Word_Count  in   ADDR_W+1  number of words to load, sampled on Start
//   Byte_In     in   8         stream data, most-significant byte of each word first
//   Byte_Valid  in   1         Byte_In is valid
//   Byte_Ready  out  1         loader accepts a byte this cycle
//   Wr_En       out  1         IM write strobe, one cycle per word
//   Wr_Addr     out  ADDR_W    IM word address
//   Wr_Data     out  WORD_W    instruction word
//   Busy        out  1         load in progress
//   Cpu_Hold    out  1         equals Busy; holds the PC and fetch
//   Done        out  1         load complete; sticky until the next Start
//   Error       out  1         checksum mismatch (CHECKSUM_EN only)
// BEHAVIOUR
//   - All outputs are registered. Reset values: Byte_Ready=0, Wr_En=0, Wr_Addr=0, Wr_Data=0, Busy=0, Done=0, Error=0.
//     Reset also sets state=IDLE, byte counter=0, word index=0.
//   - States: IDLE -> LOAD -> (CHECK) -> DONE. From DONE, Start returns to LOAD.
//   - Start in IDLE or DONE:
//     - Latch N = min(Word_Count, DEPTH); clear Done, Error and the word index.
//     - If N==0, go to DONE on the next edge with no writes.
//     - Otherwise go to LOAD.
//   - Start while in LOAD or CHECK is ignored.
//   - LOAD:
//     - Byte_Ready=1. A byte transfers on an edge where Byte_Valid && Byte_Ready.
//     - Transferred bytes are shifted into a 24-bit accumulator, MSB first; the byte counter runs 0..3 and wraps.
//     - On the 4th transfer edge: Wr_En<=1, Wr_Data<={acc,Byte_In}, Wr_Addr<=index, index++.
//     - Wr_En is high exactly one cycle. Back-to-back streaming is allowed, with no bubble between words.
//   - Completion: the edge that issues write N-1 also leaves LOAD and drops Byte_Ready.
//     - Without CHECKSUM_EN: go to DONE. Done=1 and Busy=0 are visible in the same cycle as the final Wr_En.
//   - Idle gaps (Byte_Valid=0) stall LOAD indefinitely. No timeout.
//   - Busy=1 in LOAD and CHECK only.
//   - Wr_Addr never exceeds DEPTH-1. Extra bytes after the last word are not accepted.
//   - Rst_n low mid-load: immediate return to IDLE.
//     - A partial word is discarded; no write is issued.
//     - IM contents already written are left as-is.
// CONFIGURATION
//   - Macro IM_LOADER_CHECKSUM_EN defined:
//     - After the last word, enter CHECK with Byte_Ready=1 and accept one trailer byte.
//     - Error<=(trailer != XOR of all N*4 data bytes), then go to DONE.
//     - Done and Error update on the same edge; Error is sticky until the next Start.
//   - Macro not defined: there is no CHECK state, Error is tied 0, and no trailer byte is consumed.
// STRUCTURE
//   - Package im_loader_pkg holds:
//     - typedef enum loader_state_t {IDLE, LOAD, CHECK, DONE}
//     - localparam BYTES_PER_WORD=4
//     - function clamp_count()
//   - Sub-module im_byte_packer holds the accumulator and the 2-bit byte counter.
//     - It emits a word_valid/word_data pulse; im_loader owns the FSM, the index and the write port.
// TESTING
//   1. Reset, then Start with Word_Count=3 and bytes 20,08,00,05, 8C,09,00,00, AC,0A,00,04 every cycle:
//      - Wr_En pulses at addresses 0,1,2 with data 20080005, 8C090000, AC0A0004.
//      - Done=1 in the same cycle as the third Wr_En.
//   2. Same stream with Byte_Valid toggled 1/0:
//      - Identical writes and data; Busy stays 1 throughout the gaps.
//   3. Word_Count=0:
//      - No Wr_En; Done=1 on the edge after Start; Byte_Ready stays 0.
//   4. Word_Count=40:
//      - Exactly 32 writes, addresses 0..31; the byte after word 31 sees Byte_Ready=0.
//   5. Rst_n low after 6 bytes:
//      - All outputs return to reset values; no write issued for the partial word 1.
//   6. (CHECKSUM_EN) 1 word 01,02,03,04:
//      - Trailer 04 gives Done=1, Error=0.
//      - Trailer 05 gives Done=1, Error=1.
//      - A new Start clears Error.

Source files
------------

// File: rtl/im_loader_pkg.sv
// im_loader_pkg: shared types, sizes and helpers for the instruction-memory boot loader.
package im_loader_pkg;

    localparam int IM_DEPTH       = 32;
    localparam int IM_ADDR_W      = 5;
    localparam int IM_WORD_W      = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} loader_state_t;

    function automatic int clamp_count(input int wc, input int depth);
        return (wc > depth) ? depth : wc;
    endfunction

endpackage

// File: rtl/im_loader_if.sv
// im_loader_if: start/stream/write-port bundle between the boot host (master) and im_loader (slave).
interface im_loader_if #(
    parameter int ADDR_W = im_loader_pkg::IM_ADDR_W,
    parameter int WORD_W = im_loader_pkg::IM_WORD_W
);

    logic              i_start;
    logic [ADDR_W:0]   i_word_count;
    logic [7:0]        i_byte_in;
    logic              i_byte_valid;
    logic              o_byte_ready;
    logic              o_wr_en;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [WORD_W-1:0] o_wr_data;
    logic              o_busy;
    logic              o_cpu_hold;
    logic              o_done;
    logic              o_error;

    modport master (
        output i_start, i_word_count, i_byte_in, i_byte_valid,
        input  o_byte_ready, o_wr_en, o_wr_addr, o_wr_data, o_busy, o_cpu_hold, o_done, o_error
    );

    modport slave (
        input  i_start, i_word_count, i_byte_in, i_byte_valid,
        output o_byte_ready, o_wr_en, o_wr_addr, o_wr_data, o_busy, o_cpu_hold, o_done, o_error
    );

endinterface

// File: rtl/im_byte_packer.sv
// im_byte_packer: shifts big-endian bytes into a word and flags the transfer that completes it.
module im_byte_packer
    import im_loader_pkg::*;
(
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_clear,
    input  logic                        i_fire,
    input  logic [7:0]                  i_byte,
    output logic                        o_word_valid,
    output logic [8*BYTES_PER_WORD-1:0] o_word_data
);

    logic [8*(BYTES_PER_WORD-1)-1:0] r_acc;
    logic [1:0]                      r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_fire) begin
            r_acc <= {r_acc[8*(BYTES_PER_WORD-2)-1:0], i_byte};
            r_cnt <= r_cnt + 2'd1;
        end
    end

    // The completing byte bypasses the accumulator so the word is written on that same edge.
    assign o_word_valid = i_fire && (r_cnt == 2'(BYTES_PER_WORD - 1));
    assign o_word_data  = {r_acc, i_byte};

endmodule

// File: rtl/im_loader.sv
// im_loader: boot-time IM writer; packs a byte stream into words and holds the CPU while loading.
// Define IM_LOADER_CHECKSUM_EN to require an XOR trailer byte after the last word.
module im_loader
    import im_loader_pkg::*;
#(
    parameter int DEPTH  = IM_DEPTH,
    parameter int ADDR_W = IM_ADDR_W,
    parameter int WORD_W = IM_WORD_W
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    im_loader_if.slave  bus
);

    loader_state_t     r_state;
    logic [ADDR_W:0]   r_n;
    logic [ADDR_W:0]   w_n;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [WORD_W-1:0] r_wr_data;
    logic [WORD_W-1:0] w_word_data;
    logic              r_byte_ready;
    logic              r_wr_en;
    logic              r_busy;
    logic              r_done;
    logic              w_fire;
    logic              w_clear;
    logic              w_word_valid;
    logic              w_last;
`ifdef IM_LOADER_CHECKSUM_EN
    logic [7:0]        r_csum;
    logic              r_error;
`endif

    assign w_n     = (ADDR_W+1)'(clamp_count(int'(bus.i_word_count), DEPTH));
    assign w_fire  = bus.i_byte_valid && r_byte_ready && (r_state == LOAD);
    assign w_clear = bus.i_start && !r_busy;
    assign w_last  = ({1'b0, r_idx} == r_n - (ADDR_W+1)'(1));

    im_byte_packer u_packer (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_clear      (w_clear),
        .i_fire       (w_fire),
        .i_byte       (bus.i_byte_in),
        .o_word_valid (w_word_valid),
        .o_word_data  (w_word_data)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_n          <= '0;
            r_idx        <= '0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_byte_ready <= 1'b0;
            r_wr_en      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
            r_csum       <= '0;
            r_error      <= 1'b0;
`endif
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                IDLE, DONE: if (bus.i_start) begin
                    r_n          <= w_n;
                    r_idx        <= '0;
                    r_done       <= (w_n == '0);
                    r_busy       <= (w_n != '0);
                    r_byte_ready <= (w_n != '0);
                    r_state      <= (w_n == '0) ? DONE : LOAD;
`ifdef IM_LOADER_CHECKSUM_EN
                    r_csum       <= '0;
                    r_error      <= 1'b0;
`endif
                end
                LOAD: if (w_fire) begin
`ifdef IM_LOADER_CHECKSUM_EN
                    r_csum <= r_csum ^ bus.i_byte_in;
`endif
                    if (w_word_valid) begin
                        r_wr_en   <= 1'b1;
                        r_wr_data <= w_word_data;
                        r_wr_addr <= r_idx;
                        r_idx     <= r_idx + ADDR_W'(1);
                        if (w_last) begin
`ifdef IM_LOADER_CHECKSUM_EN
                            r_state      <= CHECK;
`else
                            r_state      <= DONE;
                            r_byte_ready <= 1'b0;
                            r_busy       <= 1'b0;
                            r_done       <= 1'b1;
`endif
                        end
                    end
                end
`ifdef IM_LOADER_CHECKSUM_EN
                CHECK: if (bus.i_byte_valid) begin
                    r_error      <= (bus.i_byte_in != r_csum);
                    r_done       <= 1'b1;
                    r_busy       <= 1'b0;
                    r_byte_ready <= 1'b0;
                    r_state      <= DONE;
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.o_byte_ready = r_byte_ready;
    assign bus.o_wr_en      = r_wr_en;
    assign bus.o_wr_addr    = r_wr_addr;
    assign bus.o_wr_data    = r_wr_data;
    assign bus.o_busy       = r_busy;
    assign bus.o_cpu_hold   = r_busy;
    assign bus.o_done       = r_done;
`ifdef IM_LOADER_CHECKSUM_EN
    assign bus.o_error      = r_error;
`else
    assign bus.o_error      = 1'b0;
`endif

endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: randomized stream loads checked against a byte-array model of the loader.
module tb_im_loader;
    import im_loader_pkg::*;

`ifdef IM_LOADER_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    im_loader_if #(.ADDR_W(5), .WORD_W(32)) bus ();

    im_loader dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int n_chk = 0;
    int n_err = 0;
    logic [7:0] stream [0:199];
    logic [7:0] d1 [0:11] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h00,
                              8'hAC, 8'h0A, 8'h00, 8'h04};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_trailer(input int n, input bit bad);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < 4 * n; i++) x ^= stream[i];
        stream[4 * n] = x ^ {7'd0, bad};
    endtask

    task automatic fill_random(input int n, input bit bad);
        for (int i = 0; i < 200; i++) stream[i] = 8'($urandom);
        set_trailer(n, bad);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, bus.o_byte_ready, 0);
        check({tag, "_wr_en"}, bus.o_wr_en, 0);
        check({tag, "_wr_addr"}, bus.o_wr_addr, 0);
        check({tag, "_wr_data"}, bus.o_wr_data, 0);
        check({tag, "_busy"}, bus.o_busy, 0);
        check({tag, "_hold"}, bus.o_cpu_hold, 0);
        check({tag, "_done"}, bus.o_done, 0);
        check({tag, "_error"}, bus.o_error, 0);
    endtask

    // dens: percent chance of Byte_Valid per cycle, or -1 for strict 1/0 toggling.
    // rst_after: pulse reset once that many bytes were accepted (-1 = never).
    task automatic run_load(input int wc, input int dens, input bit bad, input int rst_after);
        int n = (wc > 32) ? 32 : wc;
        int tot = (n == 0) ? 0 : 4 * n + CS;
        int p = 0;
        int k = 0;
        int cyc = 0;
        bit fin = 0;
        bit exp_busy;
        bit exp_err;
        logic [31:0] w;
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_word_count = 6'(wc);
        bus.i_byte_valid = 1'b0;
        while (!fin) begin
            @(negedge clk);
            bus.i_start = 1'b0;
            cyc++;
            if (rst_after >= 0 && p == rst_after) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs("rst_mid");
                check("rst_prior_writes", k, rst_after / 4);
                bus.i_byte_valid = 1'b1;
                repeat (2) begin
                    @(negedge clk);
                    check_reset_outputs("rst_hold");
                end
                rst_n = 1'b1;
                @(negedge clk);
                bus.i_byte_valid = 1'b0;
                check_reset_outputs("rst_release");
                return;
            end
            exp_busy = (p < tot);
            exp_err = !exp_busy && bad && (n > 0) && (CS == 1);
            if (bus.o_wr_en) begin
                w = {stream[4*k], stream[4*k+1], stream[4*k+2], stream[4*k+3]};
                check("wr_addr", bus.o_wr_addr, k);
                check("wr_data", bus.o_wr_data, w);
                check("wr_timing", p, 4 * (k + 1));
                k++;
            end
            check("busy", bus.o_busy, exp_busy);
            check("cpu_hold", bus.o_cpu_hold, exp_busy);
            check("byte_ready", bus.o_byte_ready, exp_busy);
            check("done", bus.o_done, !exp_busy);
            check("error", bus.o_error, exp_err);
            if (!exp_busy) fin = 1;
            else if (cyc > 3000) begin
                check("timeout", 0, 1);
                fin = 1;
            end else begin
                bus.i_byte_valid = (dens < 0) ? cyc[0] : ($urandom_range(99) < dens);
                bus.i_byte_in = stream[p];
                if (bus.i_byte_valid && bus.o_byte_ready) p++;
                if ($urandom_range(15) == 0) begin
                    bus.i_start = 1'b1;
                    bus.i_word_count = 6'($urandom_range(1, 40));
                end
            end
        end
        check("write_count", k, n);
        repeat (3) begin
            bus.i_byte_valid = 1'b1;
            bus.i_byte_in = stream[p];
            @(negedge clk);
            check("ready_after_last", bus.o_byte_ready, 0);
            check("wr_after_last", bus.o_wr_en, 0);
            check("done_sticky", bus.o_done, 1);
            check("error_sticky", bus.o_error, exp_err);
        end
        bus.i_byte_valid = 1'b0;
    endtask

    initial begin
        int wc;
        bit bad;
        bus.i_start = 1'b0;
        bus.i_word_count = '0;
        bus.i_byte_in = '0;
        bus.i_byte_valid = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 200; i++) stream[i] = 8'hEE;
        for (int i = 0; i < 12; i++) stream[i] = d1[i];
        set_trailer(3, 0);
        run_load(3, 100, 0, -1);
        run_load(3, -1, 0, -1);

        fill_random(0, 0);
        run_load(0, 100, 0, -1);

        fill_random(32, 0);
        run_load(40, 100, 0, -1);

        fill_random(3, 0);
        run_load(3, 100, 0, 6);
        run_load(2, 70, 0, -1);

`ifdef IM_LOADER_CHECKSUM_EN
        for (int i = 0; i < 4; i++) stream[i] = 8'(i + 1);
        set_trailer(1, 0);
        check("trailer_good_byte", stream[4], 8'h04);
        run_load(1, 100, 0, -1);
        set_trailer(1, 1);
        run_load(1, 100, 1, -1);
        set_trailer(1, 0);
        run_load(1, 100, 0, -1);
`endif

        for (int t = 0; t < 8; t++) begin
            wc = $urandom_range(0, 40);
            bad = 1'($urandom_range(1));
            fill_random((wc > 32) ? 32 : wc, bad);
            run_load(wc, $urandom_range(20, 100), bad, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
